// File: rtl/maxpool_pkg.sv
// Shared types and helpers for the 2x2/stride-2 streaming max-pool stage.
package maxpool_pkg;

  localparam int DW_DEF = 8;
  localparam int CH_DEF = 32;
  localparam int CMP_W  = 32;

  typedef logic [CH_DEF-1:0][DW_DEF-1:0] pixel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Channels are sign-extended to CMP_W so one helper serves any DW <= CMP_W.
  function automatic logic signed [CMP_W-1:0] ch_max(
    input logic signed [CMP_W-1:0] a,
    input logic signed [CMP_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_linebuf.sv
// Half-row line buffer: one synchronous write port, one asynchronous read port.
module maxpool_linebuf #(
  parameter int DEPTH = 128,
  parameter int W     = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read: the odd-row beat needs the stored value in its own cycle.
  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 max-pool with valid/ready handshake and bypass mode.
// Optional build macro MAXPOOL_RELU_EN clamps pooled channels at zero.
module maxpool2x2_stream
  import maxpool_pkg::*;
#(
  parameter int CH       = CH_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_COLS = 256,
  parameter int COL_W    = $clog2(MAX_COLS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pool_en,
  input  logic [COL_W-1:0]   cfg_cols,
  input  logic [15:0]        cfg_rows,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH*DW-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH*DW-1:0]   out_data,
  output logic               frame_done
);

  localparam int AW = $clog2(MAX_COLS / 2);

  state_t             state_reg, state_next;
  logic [COL_W-1:0]   col_reg, cols_reg;
  logic [15:0]        row_reg, rows_reg;
  logic               pool_reg;
  logic [CH*DW-1:0]   pair_reg;
  logic               out_valid_reg;
  logic [CH*DW-1:0]   out_data_reg;
  logic               frame_done_reg;

  logic               eff_pool;
  logic [COL_W-1:0]   eff_cols;
  logic [15:0]        eff_rows;
  logic               accept;
  logic               last_col, last_row, frame_end;
  logic               lb_we, out_load;
  logic [AW-1:0]      lb_addr;
  logic [CH*DW-1:0]   lb_rdata;
  logic [CH*DW-1:0]   pool_data;

  // The first beat of a frame is accepted in IDLE, so it uses the live config.
  always_comb begin
    eff_pool   = (state_reg == IDLE) ? pool_en  : pool_reg;
    eff_cols   = (state_reg == IDLE) ? cfg_cols : cols_reg;
    eff_rows   = (state_reg == IDLE) ? cfg_rows : rows_reg;
    // A pooled result still pending from the previous frame is always drained first.
    in_ready   = eff_pool ? (!out_valid_reg || out_ready) : (!out_valid_reg && out_ready);
    out_valid  = out_valid_reg || (!eff_pool && in_valid);
    out_data   = (out_valid_reg || eff_pool) ? out_data_reg : in_data;
    accept     = in_valid && in_ready;
    last_col   = (col_reg + COL_W'(1)) >= eff_cols;
    last_row   = ({1'b0, row_reg} + 17'd1) >= {1'b0, eff_rows};
    frame_end  = last_col && last_row;
    state_next = state_reg;
    if (accept) begin
      state_next = frame_end ? IDLE : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      cols_reg       <= '0;
      rows_reg       <= '0;
      pool_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= accept && frame_end;
      if (accept) begin
        if (state_reg == IDLE) begin
          pool_reg <= pool_en;
          cols_reg <= cfg_cols;
          rows_reg <= cfg_rows;
        end
        if (last_col) begin
          col_reg <= '0;
          row_reg <= last_row ? '0 : row_reg + 16'd1;
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end
    end
  end

  assign lb_we    = accept && eff_pool && col_reg[0] && !row_reg[0];
  assign out_load = accept && eff_pool && col_reg[0] && row_reg[0];
  assign lb_addr  = col_reg[AW:1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_reg <= '0;
    end else if (accept && eff_pool && !col_reg[0]) begin
      pair_reg <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (out_load) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= pool_data;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  maxpool_linebuf #(
    .DEPTH (MAX_COLS / 2),
    .W     (CH * DW),
    .AW    (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pool_data),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // On even rows pool_data carries the horizontal max that is stored in the line buffer.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [DW-1:0] pair_ch, beat_ch, line_ch, h_ch, m_ch, sel_ch;
    assign pair_ch = pair_reg[gi*DW +: DW];
    assign beat_ch = in_data[gi*DW +: DW];
    assign line_ch = lb_rdata[gi*DW +: DW];
    assign h_ch    = DW'(ch_max(CMP_W'(pair_ch), CMP_W'(beat_ch)));
    assign m_ch    = DW'(ch_max(CMP_W'(h_ch), CMP_W'(line_ch)));
`ifdef MAXPOOL_RELU_EN
    assign sel_ch  = row_reg[0] ? (m_ch[DW-1] ? '0 : m_ch) : h_ch;
`else
    assign sel_ch  = row_reg[0] ? m_ch : h_ch;
`endif
    assign pool_data[gi*DW +: DW] = sel_ch;
  end

  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Scoreboard testbench for maxpool2x2_stream against a whole-frame 2D pooling model.
module tb_maxpool2x2_stream;

  localparam int CH       = 2;
  localparam int DW       = 8;
  localparam int MAX_COLS = 16;
  localparam int COL_W    = $clog2(MAX_COLS + 1);
  localparam int PW       = CH * DW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pool_en = 1'b1;
  logic [COL_W-1:0] cfg_cols = '0;
  logic [15:0]      cfg_rows = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [PW-1:0]    out_data;
  logic             frame_done;

  always #5 clk = ~clk;

  maxpool2x2_stream #(
    .CH       (CH),
    .DW       (DW),
    .MAX_COLS (MAX_COLS),
    .COL_W    (COL_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pool_en    (pool_en),
    .cfg_cols   (cfg_cols),
    .cfg_rows   (cfg_rows),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [PW-1:0] data;
    int            cyc;
    bit            byp;
  } exp_t;

  exp_t sb_q[$];
  int   fd_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bp_mode = 0;
  int   stall_left = 0;
  bit   stall_done = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream backpressure: 0 always ready, 1 random, 2 never, 3 one 5-cycle stall at first output
  initial forever begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      2: out_ready = 1'b0;
      default: begin
        if (!stall_done && out_valid) begin
          stall_left = 5;
          stall_done = 1'b1;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    endcase
  end

  // Monitor
  bit            held = 1'b0;
  logic [PW-1:0] held_data;
  int            first_cyc;
  exp_t          e_m;

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      held = 1'b0;
      continue;
    end
    if (frame_done) begin
      if (fd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_unexpected at cycle %0d: got pulse, expected none", cyc);
      end else begin
        chk("frame_done_cycle", cyc, fd_q.pop_front());
      end
    end
    if (out_valid && !out_ready) chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
    if (out_valid) begin
      if (!held) begin
        held      = 1'b1;
        held_data = out_data;
        first_cyc = cyc;
      end else begin
        chk("out_data_stable", {16'd0, out_data}, {16'd0, held_data});
      end
      if (out_ready) begin
        held = 1'b0;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected at cycle %0d: got %0h, expected no output", cyc, out_data);
        end else begin
          e_m = sb_q.pop_front();
          $display("out beat cycle %0d data %h", cyc, out_data);
          chk("out_data", {16'd0, out_data}, {16'd0, e_m.data});
          if (e_m.byp) chk("bypass_cycle", cyc, e_m.cyc);
          else         chk("pool_latency", first_cyc, e_m.cyc);
        end
      end
    end else if (held) begin
      checks++;
      errors++;
      $display("FAIL out_valid_dropped at cycle %0d: got 0, expected 1", cyc);
      held = 1'b0;
    end
  end

  task automatic fatal_timeout(input string what);
    errors++;
    $display("FAIL timeout_%s at cycle %0d: got no event, expected one", what, cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 || fd_q.size() != 0 || out_valid) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 500) fatal_timeout("drain");
    end
  endtask

  // mode: 0 ramp, 1 all -8 with one -3 per window, 2 random; abort_after>=0 resets after that beat
  task automatic send_frame(input bit pool, input int cols, input int rows, input int mode,
                            input int abort_after, input bit gaps);
    logic [PW-1:0]        pix[$];
    logic [PW-1:0]        exp_v[$];
    logic [PW-1:0]        p, q, res;
    logic signed [DW-1:0] v, m;
    exp_t                 e;
    int                   n, r, c, t, idx;
    n = cols * rows;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       p = {CH{8'(i)}};
        1:       p = {CH{8'hF8}};
        default: p = PW'($urandom);
      endcase
      pix.push_back(p);
    end
    if (mode == 1) begin
      for (int wr = 0; wr < rows / 2; wr++)
        for (int wc = 0; wc < cols / 2; wc++) begin
          idx = (2 * wr + int'($urandom_range(0, 1))) * cols + 2 * wc + int'($urandom_range(0, 1));
          pix[idx] = {CH{8'hFD}};
        end
    end
    if (pool) begin
      for (int wr = 0; wr < rows / 2; wr++)
        for (int wc = 0; wc < cols / 2; wc++) begin
          for (int ch = 0; ch < CH; ch++) begin
            m = -128;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++) begin
                q = pix[(2 * wr + dr) * cols + 2 * wc + dc];
                v = q[ch*DW +: DW];
                if (v > m) m = v;
              end
`ifdef MAXPOOL_RELU_EN
            if (m < 0) m = 0;
`endif
            res[ch*DW +: DW] = m;
          end
          exp_v.push_back(res);
        end
    end
    $display("frame pool=%0d cols=%0d rows=%0d mode=%0d abort=%0d", pool, cols, rows, mode, abort_after);
    pool_en  = pool;
    cfg_cols = COL_W'(cols);
    cfg_rows = 16'(rows);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = pix[i];
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 200) fatal_timeout("in_ready");
      end
      r = i / cols;
      c = i % cols;
      if (abort_after < 0) begin
        if (pool && (r % 2 == 1) && (c % 2 == 1)) begin
          e.data = exp_v.pop_front();
          e.cyc  = cyc + 1;
          e.byp  = 1'b0;
          sb_q.push_back(e);
        end
        if (!pool) begin
          e.data = pix[i];
          e.cyc  = cyc;
          e.byp  = 1'b1;
          sb_q.push_back(e);
        end
        if (i == n - 1) fd_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
      if (i == 0) begin
        pool_en  = 1'($urandom);
        cfg_cols = COL_W'($urandom);
        cfg_rows = 16'($urandom_range(0, 3));
      end
      if (i == abort_after) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    pool_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data", {16'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;

    bp_mode = 0;
    send_frame(1'b1, 4, 4, 0, -1, 1'b0);
    send_frame(1'b1, 4, 4, 1, -1, 1'b0);
    drain();

    stall_done = 1'b0;
    bp_mode    = 3;
    send_frame(1'b1, 4, 4, 2, -1, 1'b0);
    drain();
    bp_mode = 0;

    send_frame(1'b1, 5, 3, 2, -1, 1'b0);
    send_frame(1'b0, 3, 1, 2, -1, 1'b0);
    drain();

    bp_mode = 2;
    send_frame(1'b1, 4, 4, 2, 5, 1'b0);
    bp_mode = 0;
    send_frame(1'b1, 4, 4, 2, -1, 1'b0);

    send_frame(1'b1, 1, 5, 2, -1, 1'b1);
    send_frame(1'b1, 6, 1, 2, -1, 1'b1);

    bp_mode = 1;
    repeat (20) begin
      send_frame(1'($urandom_range(0, 1)), int'($urandom_range(1, MAX_COLS)),
                 int'($urandom_range(1, 6)), 2, -1, 1'b1);
    end
    bp_mode = 0;
    drain();
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    chk("frame_done_pending", fd_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool2x2_stream.md
# maxpool2x2_stream

Parametrised streaming 2×2/stride-2 max-pool stage for the CNN datapath, sitting between the convolution output and the feature-map writer. It accepts one pixel (CH signed channels) per beat in raster order. It performs true two-dimensional pooling, horizontally within a row and vertically across row pairs, using an internal half-row line buffer. Valid/ready handshaking on both sides replaces the previous fixed-latency pool stage, and a bypass mode forwards data unpooled.

## Interface
- CH, 32, channels per pixel beat
- DW, 8, bits per channel, two's complement
- MAX_COLS, 256, maximum row length in pixels (even)
- COL_W, $clog2(MAX_COLS+1), column counter width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pool_en  in  1  1 = pool, 0 = bypass; sampled at frame start
- cfg_cols  in  COL_W  pixels per input row; sampled at frame start
- cfg_rows  in  16  rows per input frame; sampled at frame start
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_data  in  CH*DW  channel c at bits [DW*(c+1)-1 : DW*c]
- out_valid  out  1  output beat valid, held until accepted
- out_ready  in  1  downstream accept
- out_data  out  CH*DW  pooled pixel, same packing
- frame_done  out  1  single-cycle pulse, end of frame

## Operation
- FSM states are IDLE and RUN. IDLE→RUN on the first accepted beat, which also latches pool_en, cfg_cols and cfg_rows. RUN→IDLE on acceptance of beat (cfg_rows-1, cfg_cols-1).
- Counters: col (0..cfg_cols-1) and row (0..cfg_rows-1). col wraps to 0 and row increments at the end of each row.
- Pool mode, even col: the beat is held in a pair register.
- Pool mode, odd col: h = per-channel signed max(pair, beat).
  - On an even row, h is written to line buffer entry col>>1.
  - On an odd row, out = max(h, linebuf[col>>1]) and is loaded into the output register.
- Comparisons are signed and per channel. Ties are irrelevant because equal values give identical output. No width growth: out is DW bits.
- Odd cfg_cols: the last column is consumed and discarded. Odd cfg_rows: the last row is consumed, and no outputs are produced from it.
- cfg_cols<2 or cfg_rows<2: the frame is consumed, produces no outputs, and frame_done still fires.
- in_ready = !out_valid | out_ready in pool mode. Beats that produce no output are still stalled by this rule, which keeps the logic simple.
- Bypass mode: out_valid = in_valid, out_data = in_data, in_ready = out_ready, all combinational. The counters still track the frame for frame_done.
- frame_done is registered and asserts in the cycle after the final input beat of the frame is accepted.
- Reset values: out_valid 0, out_data 0, frame_done 0, FSM IDLE, counters 0. in_ready reads 1 after reset.
- Line buffer contents are not reset. Every even row overwrites them before use.
- Reset mid-frame aborts the frame. No frame_done is issued, and the next accepted beat starts a new frame.

## Timing
- Pool-mode latency: output beat valid 1 cycle after acceptance of the odd-row/odd-col input beat.
- Throughput: 1 input beat/cycle while out_ready=1. Output rate is ¼ of the input rate.
- out_valid/out_data stay stable while out_valid & !out_ready. No output beat is dropped or duplicated.
- Line buffer: synchronous write on even rows. Read address is valid in the same cycle as the odd-column beat (registered-output RAM not allowed); a distributed/flop array is acceptable.
- pool_en/cfg changes during RUN have no effect until the next frame.

## Configuration
- MAXPOOL_RELU_EN defined: each pooled channel is clamped to max(result, 0) before the output register. Applies in pool mode only; bypass is unaffected.
- Not defined: raw signed max is output, and negative values pass through.

## Structure
- Package maxpool_pkg: DW/CH defaults, pixel typedef (logic signed [DW-1:0] array of CH), state enum {IDLE, RUN}, and a function for the per-channel vector max.
- Sub-module maxpool_linebuf: MAX_COLS/2 entries × CH*DW, 1 write port, 1 async read port.

## Test plan
- CH=2, DW=8, 4×4 frame with ramp values 0..15 (both channels), out_ready=1 -> outputs 5, 7, 13, 15 in order; frame_done 1 cycle after beat 15; no other out_valid.
- Negative data, all pixels -8 except one -3 per window -> outputs -3. With MAXPOOL_RELU_EN, outputs are 0.
- 4×4 frame with out_ready held 0 for 5 cycles at first output -> in_ready drops, data held stable, and all 4 outputs appear exactly once.
- Odd dims: 5×3 frame (cols×rows) -> 2 outputs; frame_done after the 15th beat.
- pool_en=0, 3-beat frame (cfg 3×1) -> out mirrors in, same cycle; frame_done after the 3rd beat.
- rst_n low for 1 cycle after 6 beats of a 4×4 frame, then a fresh 4×4 frame -> only the fresh frame's 4 outputs and 1 frame_done.
